// File: rtl/cmp_arbiter_pkg.sv
// rtl/cmp_arbiter_pkg.sv - shared comparator codes, condition op encodings and op evaluation
//
// Contents:
//   cmp_*   : 2-bit code of A vs B (00 = none)
//   zero_*  : 2-bit code of A vs 0 (00 = none)
//   cmpop_* : 4-bit condition op encodings; 10..15 are reserved and never true
//   state_e : arbiter FSM states
//   eval_op : resolves a condition op from the cmp and zero codes
package cmp_arbiter_pkg;

  localparam logic [1:0] cmp_none  = 2'b00;
  localparam logic [1:0] cmp_eq    = 2'b01;
  localparam logic [1:0] cmp_gt    = 2'b10;
  localparam logic [1:0] cmp_lt    = 2'b11;

  localparam logic [1:0] zero_none = 2'b00;
  localparam logic [1:0] zero_eq   = 2'b01;
  localparam logic [1:0] zero_gt   = 2'b10;
  localparam logic [1:0] zero_lt   = 2'b11;

  localparam logic [3:0] cmpop_eq  = 4'd0;
  localparam logic [3:0] cmpop_ne  = 4'd1;
  localparam logic [3:0] cmpop_lez = 4'd2;
  localparam logic [3:0] cmpop_gtz = 4'd3;
  localparam logic [3:0] cmpop_ltz = 4'd4;
  localparam logic [3:0] cmpop_gez = 4'd5;
  localparam logic [3:0] cmpop_ge  = 4'd6;
  localparam logic [3:0] cmpop_lt  = 4'd7;
  localparam logic [3:0] cmpop_gt  = 4'd8;
  localparam logic [3:0] cmpop_le  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic eval_op(input logic [3:0] op,
                                   input logic [1:0] cmp,
                                   input logic [1:0] zero);
    logic taken;
    taken = 1'b0;
    case (op)
      cmpop_eq:  taken = (cmp == cmp_eq);
      cmpop_ne:  taken = (cmp != cmp_eq);
      cmpop_lez: taken = (zero == zero_eq) || (zero == zero_lt);
      cmpop_gtz: taken = (zero == zero_gt);
      cmpop_ltz: taken = (zero == zero_lt);
      cmpop_gez: taken = (zero == zero_eq) || (zero == zero_gt);
      cmpop_ge:  taken = (cmp == cmp_eq) || (cmp == cmp_gt);
      cmpop_lt:  taken = (cmp == cmp_lt);
      cmpop_gt:  taken = (cmp == cmp_gt);
      cmpop_le:  taken = (cmp == cmp_eq) || (cmp == cmp_lt);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// rtl/cmp_arbiter_cmp.sv - signed comparator producing A-vs-B and A-vs-0 codes
//
// Ports:
//   a_i, b_i : W-bit signed operands
//   cmp_o    : cmp_eq / cmp_gt / cmp_lt of a_i vs b_i (eq checked first, then gt)
//   zero_o   : zero_eq / zero_gt / zero_lt of a_i vs 0
module cmp_arbiter_cmp
  import cmp_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [1:0]   cmp_o,
  output logic [1:0]   zero_o
);

  always_comb begin
    cmp_o = cmp_lt;
    if ($signed(a_i) == $signed(b_i)) begin
      cmp_o = cmp_eq;
    end else if ($signed(a_i) > $signed(b_i)) begin
      cmp_o = cmp_gt;
    end
  end

  // Sign bit alone decides negative; any other non-zero value is positive.
  always_comb begin
    zero_o = zero_gt;
    if (a_i == '0) begin
      zero_o = zero_eq;
    end else if (a_i[W-1]) begin
      zero_o = zero_lt;
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - two-port arbiter in front of one shared signed comparator
//
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   req_valid[1:0]          : per-port request valid (0 = branch unit, 1 = trap unit)
//   req_ready[1:0]          : one-hot grant, combinational
//   req_a0/b0, req_a1/b1    : per-port W-bit operands
//   req_op0, req_op1        : per-port 4-bit condition op
//   rsp_valid, rsp_ready    : result handshake
//   rsp_id                  : port owning the result
//   rsp_cmp, rsp_zero       : comparator codes of the latched operands (00 while idle)
//   rsp_taken               : latched condition op evaluated true
//   flush                   : drops the held result and suppresses this cycle's grant
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int W          = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [3:0]   req_op0,
  input  logic [3:0]   req_op1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [1:0]   rsp_cmp,
  output logic [1:0]   rsp_zero,
  output logic         rsp_taken,
  input  logic         flush
);

  state_e       state_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic         rr_ptr_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [3:0]   op_q;

  logic         can_accept;
  logic         grant_d;
  logic         winner_d;
  logic [1:0]   cmp_w;
  logic [1:0]   zero_w;

  // A held result frees the comparator in the same cycle it is consumed,
  // which is what gives back-to-back throughput.
  assign can_accept = (state_q == ST_IDLE) || (rsp_valid_q && rsp_ready);

  always_comb begin
    grant_d  = can_accept && !flush && (req_valid != 2'b00);
    winner_d = 1'b0;
    if (req_valid == 2'b11) begin
      winner_d = (PRIO_FIXED != 0) ? 1'b0 : rr_ptr_q;
    end else begin
      winner_d = req_valid[1];
    end
    req_ready = 2'b00;
    if (grant_d) begin
      req_ready = winner_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rr_ptr_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'd0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
    end else if (grant_d) begin
      state_q     <= ST_HOLD;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= winner_d;
      rr_ptr_q    <= ~winner_d;
      a_q         <= winner_d ? req_a1 : req_a0;
      b_q         <= winner_d ? req_b1 : req_b0;
      op_q        <= winner_d ? req_op1 : req_op0;
    end else if ((state_q == ST_HOLD) && rsp_ready) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
    end
  end

  cmp_arbiter_cmp #(
    .W(W)
  ) u_cmp (
    .a_i   (a_q),
    .b_i   (b_q),
    .cmp_o (cmp_w),
    .zero_o(zero_w)
  );

  // Codes are masked while no result is held so idle outputs read as "none".
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_cmp   = rsp_valid_q ? cmp_w : cmp_none;
  assign rsp_zero  = rsp_valid_q ? zero_w : zero_none;
  assign rsp_taken = rsp_valid_q && eval_op(op_q, cmp_w, zero_w);

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter
module tb_cmp_arbiter;
  import cmp_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic        rsp_ready;
  logic        flush;

  logic [1:0]  rr_req_ready, fx_req_ready;
  logic        rr_rsp_valid, fx_rsp_valid;
  logic        rr_rsp_id, fx_rsp_id;
  logic [1:0]  rr_rsp_cmp, fx_rsp_cmp;
  logic [1:0]  rr_rsp_zero, fx_rsp_zero;
  logic        rr_rsp_taken, fx_rsp_taken;

  int checks;
  int failures;

  cmp_arbiter #(.PRIO_FIXED(0), .W(32)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rr_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id), .rsp_cmp(rr_rsp_cmp),
    .rsp_zero(rr_rsp_zero), .rsp_taken(rr_rsp_taken), .flush(flush)
  );

  cmp_arbiter #(.PRIO_FIXED(1), .W(32)) dut_fx (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fx_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(fx_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id), .rsp_cmp(fx_rsp_cmp),
    .rsp_zero(fx_rsp_zero), .rsp_taken(fx_rsp_taken), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [1:0] c, input logic [1:0] z, input logic t);
    check({tag, ".rsp_valid"}, {31'd0, rr_rsp_valid}, {31'd0, v});
    check({tag, ".rsp_id"},    {31'd0, rr_rsp_id},    {31'd0, id});
    check({tag, ".rsp_cmp"},   {30'd0, rr_rsp_cmp},   {30'd0, c});
    check({tag, ".rsp_zero"},  {30'd0, rr_rsp_zero},  {30'd0, z});
    check({tag, ".rsp_taken"}, {31'd0, rr_rsp_taken}, {31'd0, t});
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [1:0]  ecmp;
    logic [1:0]  ezero;
    logic        etaken;
  } vec_t;

  vec_t vecs[11];

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = 4'd0; req_op1 = 4'd0;
    rsp_ready = 1'b0;
    flush     = 1'b0;

    vecs[0]  = '{1'b0, 32'd5,        32'd5,        cmpop_eq,  cmp_eq, zero_gt, 1'b1};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, cmpop_lt,  cmp_lt, zero_lt, 1'b1};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, cmpop_ge,  cmp_lt, zero_lt, 1'b0};
    vecs[3]  = '{1'b0, 32'd0,        32'd7,        cmpop_lez, cmp_lt, zero_eq, 1'b1};
    vecs[4]  = '{1'b1, 32'd0,        32'd7,        cmpop_gtz, cmp_lt, zero_eq, 1'b0};
    vecs[5]  = '{1'b0, 32'd0,        32'd7,        cmpop_gez, cmp_lt, zero_eq, 1'b1};
    vecs[6]  = '{1'b0, 32'd0,        32'd7,        4'd12,     cmp_lt, zero_eq, 1'b0};
    vecs[7]  = '{1'b1, 32'd3,        32'hFFFFFFFE, cmpop_gt,  cmp_gt, zero_gt, 1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cmpop_ne,  cmp_eq, zero_lt, 1'b0};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, cmpop_le,  cmp_gt, zero_gt, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd0,        cmpop_ltz, cmp_lt, zero_lt, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check_rsp("reset", 1'b0, 1'b0, cmp_none, zero_none, 1'b0);
    check("reset.req_ready", {30'd0, rr_req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Rsp_ready while idle is ignored
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready.rsp_valid", {31'd0, rr_rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    // Table of single requests
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].port) begin
        req_a1 = vecs[i].a; req_b1 = vecs[i].b; req_op1 = vecs[i].op; req_valid = 2'b10;
      end else begin
        req_a0 = vecs[i].a; req_b0 = vecs[i].b; req_op0 = vecs[i].op; req_valid = 2'b01;
      end
      #1;
      check($sformatf("vec%0d.req_ready", i), {30'd0, rr_req_ready},
            vecs[i].port ? 32'd2 : 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      #1;
      check_rsp($sformatf("vec%0d", i), 1'b1, vecs[i].port, vecs[i].ecmp,
                vecs[i].ezero, vecs[i].etaken);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.drain", i), {31'd0, rr_rsp_valid}, 32'd0);
      rsp_ready = 1'b0;
    end

    // Asynchronous reset while a result is held
    req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = cmpop_eq; req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("hold.rsp_valid", {31'd0, rr_rsp_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_rsp("async_reset", 1'b0, 1'b0, cmp_none, zero_none, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Contention, both ports valid with rsp_ready=1
    req_a0 = 32'd10; req_b0 = 32'd20; req_op0 = cmpop_lt;
    req_a1 = 32'd30; req_b1 = 32'd30; req_op1 = cmpop_eq;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), {30'd0, rr_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("fx_grant%0d", i), {30'd0, fx_req_ready}, 32'd1);
      if (i > 0) begin
        check($sformatf("rr_rsp_id%0d", i), {31'd0, rr_rsp_id}, ((i - 1) % 2 == 0) ? 32'd0 : 32'd1);
        check($sformatf("fx_rsp_id%0d", i), {31'd0, fx_rsp_id}, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("rr_rsp_id_last", {31'd0, rr_rsp_id}, 32'd1);
    check("rr_last.rsp_cmp", {30'd0, rr_rsp_cmp}, {30'd0, cmp_eq});
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Backpressure: port 0 result held while port 1 waits
    req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = cmpop_lt; req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_a1 = 32'd9; req_b1 = 32'd9; req_op1 = cmpop_ne; req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d.req_ready", i), {30'd0, rr_req_ready}, 32'd0);
      check_rsp($sformatf("bp%0d", i), 1'b1, 1'b0, cmp_lt, zero_gt, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release.req_ready", {30'd0, rr_req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #1;
    check_rsp("bp_next", 1'b1, 1'b1, cmp_eq, zero_gt, 1'b0);

    // Flush against a port 0 handshake attempt while holding
    req_a0 = 32'd4; req_b0 = 32'd4; req_op0 = cmpop_eq; req_valid = 2'b01;
    rsp_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("flush.req_ready", {30'd0, rr_req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #1;
    check("flush.rsp_valid", {31'd0, rr_rsp_valid}, 32'd0);
    check("flush.rsp_cmp", {30'd0, rr_rsp_cmp}, 32'd0);
    req_valid = 2'b11;
    #1;
    check("flush.rr_ptr", {30'd0, rr_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    check_rsp("post_flush", 1'b1, 1'b0, cmp_eq, zero_gt, 1'b1);
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
